host_sequencer: RTL and testbench

- Host-side initiator for the processor's req/done run handshake. It drives the core the way a test harness or host would.
- Sequence: stream operand bytes into data memory through its write port, pulse req, wait for done under a timeout, then stream result bytes back out of data memory.
- Sits beside the core top level. It shares the data-memory port through a mux that the integrator selects with busy.

---
 rtl/host_seq_pkg.sv | 15 +
 rtl/host_seq_unload.sv | 61 ++++++
 rtl/host_sequencer.sv | 149 ++++++++++++++
 tb/tb_host_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/host_seq_pkg.sv
// rtl/host_seq_pkg.sv - shared state encoding and defaults for the host sequencer
package host_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LAUNCH,
    ST_RUN,
    ST_UNLOAD,
    ST_DONE
  } state_e;

  localparam int TIMEOUT_DEFAULT = 4096;

endpackage

// File: rtl/host_seq_unload.sv
// rtl/host_seq_unload.sv - result fetch stage: address, read latch and valid hold
module host_seq_unload #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          active,
  input  logic [AW-1:0] ul_base,
  input  logic [AW-1:0] ul_len,
  input  logic [DW-1:0] mem_rd_data,
  input  logic          out_ready,
  output logic [AW-1:0] mem_addr,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          last_done
);

  logic [AW-1:0] ul_idx_q, ul_idx_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          hs;

  // Address wraps naturally at 2^AW because the sum is truncated to AW bits.
  assign mem_addr  = active ? (ul_base + ul_idx_q) : '0;
  assign hs        = out_valid_q && out_ready;
  assign last_done = active && hs && (ul_idx_q == ul_len - AW'(1));
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Fetch when empty, hold until accepted, then drop valid for one fetch cycle.
  always_comb begin
    ul_idx_d    = ul_idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (!active) begin
      ul_idx_d    = '0;
      out_valid_d = 1'b0;
    end else if (!out_valid_q) begin
      out_valid_d = 1'b1;
      out_data_d  = mem_rd_data;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      ul_idx_d    = ul_idx_q + AW'(1);
    end
  end

  // Stage registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ul_idx_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      ul_idx_q    <= ul_idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: rtl/host_sequencer.sv
// rtl/host_sequencer.sv - host-side load / launch / run / unload sequencer for the core
module host_sequencer
  import host_seq_pkg::*;
#(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int CW      = 16,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] ld_len,
  input  logic [AW-1:0] ul_base,
  input  logic [AW-1:0] ul_len,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wr_data,
  input  logic [DW-1:0] mem_rd_data,
  output logic          core_req,
  input  logic          core_done,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          timeout_err,
  output logic [CW-1:0] run_cycles
);

  localparam logic [CW-1:0] RUN_MAX = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] ld_len_q, ld_len_d;
  logic [AW-1:0] ul_base_q, ul_base_d;
  logic [AW-1:0] ul_len_q, ul_len_d;
  logic [AW-1:0] ld_idx_q, ld_idx_d;
  logic [CW-1:0] run_cycles_q, run_cycles_d;
  logic          timeout_err_q, timeout_err_d;

  logic          ld_last;
  logic          run_limit;
  logic          unload_active;
  logic          ul_last;
  logic [AW-1:0] ul_addr;

  assign ld_last     = (ld_idx_q == ld_len_q - AW'(1));
  assign run_limit   = (run_cycles_q == RUN_MAX);
  assign timeout_err = timeout_err_q;
  assign run_cycles  = run_cycles_q;

  host_seq_unload #(.AW(AW), .DW(DW)) u_unload (
    .clk         (clk),
    .reset       (reset),
    .active      (unload_active),
    .ul_base     (ul_base_q),
    .ul_len      (ul_len_q),
    .mem_rd_data (mem_rd_data),
    .out_ready   (out_ready),
    .mem_addr    (ul_addr),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .last_done   (ul_last)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a done seen on the limit cycle still counts as success.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = (ld_len != '0) ? ST_LOAD : ST_LAUNCH;
      ST_LOAD:   if (in_valid && ld_last) state_d = ST_LAUNCH;
      ST_LAUNCH: state_d = ST_RUN;
      ST_RUN: begin
        if (core_done)      state_d = (ul_len_q != '0) ? ST_UNLOAD : ST_DONE;
        else if (run_limit) state_d = ST_DONE;
      end
      ST_UNLOAD: if (ul_last) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs; the memory port is only driven in LOAD and UNLOAD.
  always_comb begin
    busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);
    in_ready      = (state_q == ST_LOAD);
    mem_wr_en     = (state_q == ST_LOAD) && in_valid;
    mem_wr_data   = (state_q == ST_LOAD) ? in_data : '0;
    core_req      = (state_q == ST_LAUNCH);
    unload_active = (state_q == ST_UNLOAD);
    mem_addr      = (state_q == ST_LOAD) ? ld_idx_q : ul_addr;
  end

  // Captured lengths, load index, run counter and timeout flag.
  always_comb begin
    ld_len_d      = ld_len_q;
    ul_base_d     = ul_base_q;
    ul_len_d      = ul_len_q;
    ld_idx_d      = ld_idx_q;
    run_cycles_d  = run_cycles_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ld_len_d      = ld_len;
          ul_base_d     = ul_base;
          ul_len_d      = ul_len;
          ld_idx_d      = '0;
          run_cycles_d  = '0;
          timeout_err_d = 1'b0;
        end
      end
      ST_LOAD: if (in_valid) ld_idx_d = ld_idx_q + AW'(1);
      ST_RUN: begin
        run_cycles_d = run_limit ? run_cycles_q : run_cycles_q + CW'(1);
        if (!core_done && run_limit) timeout_err_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_len_q      <= '0;
      ul_base_q     <= '0;
      ul_len_q      <= '0;
      ld_idx_q      <= '0;
      run_cycles_q  <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      ld_len_q      <= ld_len_d;
      ul_base_q     <= ul_base_d;
      ul_len_q      <= ul_len_d;
      ld_idx_q      <= ld_idx_d;
      run_cycles_q  <= run_cycles_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_host_sequencer.sv
// tb/tb_host_sequencer.sv - directed self-checking bench for host_sequencer
module tb_host_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] ld_len = '0, ul_base = '0, ul_len = '0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready, mem_wr_en, core_req, out_valid, busy, timeout_err;
  logic [7:0] mem_addr, mem_wr_data, mem_rd_data, out_data;
  logic       core_done = 1'b0;
  logic       out_ready = 1'b1;
  logic [15:0] run_cycles;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [256];
  logic [7:0] src_q[$];
  logic [7:0] wr_addr_q[$], wr_data_q[$], out_q[$], rd_addr_q[$];
  int  req_pulses, post_req_busy, out_valid_cycles, stall_cycles, gap_write_err, stable_err;
  bit  req_seen, prev_v, prev_hs;
  logic [7:0] prev_d;
  bit  gap_en = 0;
  int  stall_left = 0;
  int  done_delay = 5;
  int  done_cnt = 0;
  bit  done_armed = 0;
  int  src_cyc = 0;

  assign mem_rd_data = mem[mem_addr];

  host_sequencer #(.AW(8), .DW(8), .CW(16), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .start(start), .ld_len(ld_len), .ul_base(ul_base), .ul_len(ul_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .core_req(core_req), .core_done(core_done),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .timeout_err(timeout_err), .run_cycles(run_cycles)
  );

  initial forever #5 clk = ~clk;

  // Memory model and observation of everything crossing the DUT boundary.
  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_addr] = mem_wr_data;
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wr_data);
      if (!in_valid) gap_write_err++;
    end
    if (in_valid && in_ready && src_q.size() > 0) void'(src_q.pop_front());
    if (core_req) begin
      req_pulses++;
      req_seen = 1;
    end else if (busy && req_seen) post_req_busy++;
    if (out_valid) out_valid_cycles++;
    if (out_valid && !out_ready) stall_cycles++;
    if (prev_v && !prev_hs && (!out_valid || out_data !== prev_d)) stable_err++;
    if (out_valid && out_ready) begin
      out_q.push_back(out_data);
      rd_addr_q.push_back(mem_addr);
    end
    prev_v  = out_valid;
    prev_hs = out_valid && out_ready;
    prev_d  = out_data;
  end

  // Load-stream source, result sink with optional stall, and core model.
  initial forever begin
    @(negedge clk);
    src_cyc++;
    in_valid = (src_q.size() > 0) && !(gap_en && src_cyc[0]);
    in_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
    out_ready = !(out_valid && stall_left > 0);
    if (!out_ready) stall_left--;
    if (done_delay == 0) core_done = 1'b1;
    else begin
      if (core_req) begin
        done_armed = 1;
        done_cnt = 0;
      end else if (done_armed) done_cnt++;
      core_done = done_armed && (done_delay > 0) && (done_cnt >= done_delay);
    end
  end

  task automatic clear_logs;
    wr_addr_q.delete(); wr_data_q.delete(); out_q.delete(); rd_addr_q.delete();
    req_pulses = 0; post_req_busy = 0; out_valid_cycles = 0; stall_cycles = 0;
    gap_write_err = 0; stable_err = 0; req_seen = 0; prev_v = 0; prev_hs = 0;
  endtask

  task automatic start_seq(input logic [7:0] ll, input logic [7:0] ub, input logic [7:0] ul);
    @(negedge clk);
    ld_len = ll; ul_base = ub; ul_len = ul; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_not_busy(input string name);
    int n;
    n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++; failures++;
      $display("FAIL %s_busy_timeout busy=%0b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, in_ready, mem_wr_en, core_req, out_valid, timeout_err} !== 6'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=000000", {busy, in_ready, mem_wr_en, core_req, out_valid, timeout_err});
    end
    checks++;
    if (mem_addr !== 8'h00 || out_data !== 8'h00) begin
      failures++; $display("FAIL reset_data mem_addr=%h out_data=%h exp=00/00", mem_addr, out_data);
    end
    checks++;
    if (run_cycles !== 16'd0) begin
      failures++; $display("FAIL reset_run_cycles got=%0d exp=0", run_cycles);
    end
    reset = 1'b1;
  endtask

  task automatic test_load_unload;
    logic [7:0] ea [3];
    logic [7:0] ed [3];
    logic [7:0] eo [2];
    logic [7:0] g;
    ea = '{8'h00, 8'h01, 8'h02};
    ed = '{8'h11, 8'h22, 8'h33};
    eo = '{8'hAA, 8'hBB};
    mem[8'h80] = 8'hAA; mem[8'h81] = 8'hBB;
    clear_logs();
    gap_en = 0; stall_left = 0; done_delay = 5;
    src_q = '{8'h11, 8'h22, 8'h33};
    start_seq(8'd3, 8'h80, 8'd2);
    wait_not_busy("load_unload");
    checks++;
    if (wr_addr_q.size() != 3) begin
      failures++; $display("FAIL lu_write_count got=%0d exp=3", wr_addr_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      g = (i < wr_addr_q.size()) ? wr_addr_q[i] : 8'hxx;
      if (g !== ea[i]) begin failures++; $display("FAIL lu_write_addr[%0d] got=%h exp=%h", i, g, ea[i]); end
      checks++;
      g = (i < wr_data_q.size()) ? wr_data_q[i] : 8'hxx;
      if (g !== ed[i]) begin failures++; $display("FAIL lu_write_data[%0d] got=%h exp=%h", i, g, ed[i]); end
    end
    checks++;
    if (req_pulses != 1) begin failures++; $display("FAIL lu_req_pulses got=%0d exp=1", req_pulses); end
    checks++;
    if (run_cycles !== 16'd5) begin failures++; $display("FAIL lu_run_cycles got=%0d exp=5", run_cycles); end
    checks++;
    if (out_q.size() != 2) begin failures++; $display("FAIL lu_out_count got=%0d exp=2", out_q.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      g = (i < out_q.size()) ? out_q[i] : 8'hxx;
      if (g !== eo[i]) begin failures++; $display("FAIL lu_out_data[%0d] got=%h exp=%h", i, g, eo[i]); end
    end
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL lu_end_flags timeout_err=%b busy=%b exp=0/0", timeout_err, busy);
    end
  endtask

  task automatic test_backpressure_gaps;
    logic [7:0] ed [4];
    logic [7:0] eo [2];
    logic [7:0] g;
    ed = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};
    eo = '{8'h01, 8'h02};
    mem[8'h10] = 8'h01; mem[8'h11] = 8'h02;
    clear_logs();
    gap_en = 1; stall_left = 4; done_delay = 2;
    src_q = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};
    start_seq(8'd4, 8'h10, 8'd2);
    wait_not_busy("backpressure");
    gap_en = 0;
    checks++;
    if (wr_data_q.size() != 4) begin failures++; $display("FAIL bp_write_count got=%0d exp=4", wr_data_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      g = (i < wr_data_q.size()) ? wr_data_q[i] : 8'hxx;
      if (g !== ed[i] || (i < wr_addr_q.size() && wr_addr_q[i] !== 8'(i))) begin
        failures++; $display("FAIL bp_write[%0d] got=%h exp=%h", i, g, ed[i]);
      end
    end
    checks++;
    if (gap_write_err != 0) begin failures++; $display("FAIL bp_gap_write got=%0d exp=0", gap_write_err); end
    checks++;
    if (stall_cycles != 4) begin failures++; $display("FAIL bp_stall_cycles got=%0d exp=4", stall_cycles); end
    checks++;
    if (stable_err != 0) begin failures++; $display("FAIL bp_out_stable got=%0d exp=0", stable_err); end
    checks++;
    if (out_q.size() != 2) begin failures++; $display("FAIL bp_out_count got=%0d exp=2", out_q.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      g = (i < out_q.size()) ? out_q[i] : 8'hxx;
      if (g !== eo[i]) begin failures++; $display("FAIL bp_out_data[%0d] got=%h exp=%h", i, g, eo[i]); end
    end
    checks++;
    if (run_cycles !== 16'd2) begin failures++; $display("FAIL bp_run_cycles got=%0d exp=2", run_cycles); end
  endtask

  task automatic test_timeout;
    clear_logs();
    done_delay = -1;
    start_seq(8'd0, 8'h00, 8'd2);
    wait_not_busy("timeout");
    checks++;
    if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_flag got=%b exp=1", timeout_err); end
    checks++;
    if (run_cycles !== 16'd15) begin failures++; $display("FAIL to_run_cycles got=%0d exp=15", run_cycles); end
    checks++;
    if (post_req_busy != 16) begin failures++; $display("FAIL to_run_len got=%0d exp=16", post_req_busy); end
    checks++;
    if (out_valid_cycles != 0) begin failures++; $display("FAIL to_out_valid got=%0d exp=0", out_valid_cycles); end
    repeat (3) @(negedge clk);
    checks++;
    if (timeout_err !== 1'b1 || run_cycles !== 16'd15) begin
      failures++; $display("FAIL to_hold timeout_err=%b run_cycles=%0d exp=1/15", timeout_err, run_cycles);
    end
  endtask

  task automatic test_zero_early_done;
    clear_logs();
    done_delay = 0;
    start_seq(8'd0, 8'h40, 8'd0);
    checks++;
    if (core_req !== 1'b1) begin failures++; $display("FAIL zd_launch_next got=%b exp=1", core_req); end
    checks++;
    if (timeout_err !== 1'b0) begin failures++; $display("FAIL zd_err_cleared got=%b exp=0", timeout_err); end
    wait_not_busy("zero_done");
    checks++;
    if (post_req_busy != 1) begin failures++; $display("FAIL zd_run_len got=%0d exp=1", post_req_busy); end
    checks++;
    if (run_cycles !== 16'd1) begin failures++; $display("FAIL zd_run_cycles got=%0d exp=1", run_cycles); end
    checks++;
    if (wr_addr_q.size() != 0 || out_valid_cycles != 0) begin
      failures++; $display("FAIL zd_mem_traffic writes=%0d out_valid=%0d exp=0/0", wr_addr_q.size(), out_valid_cycles);
    end
    done_delay = 1;
  endtask

  task automatic test_wrap;
    logic [7:0] ea [3];
    logic [7:0] eo [3];
    logic [7:0] g;
    ea = '{8'hFE, 8'hFF, 8'h00};
    eo = '{8'h71, 8'h72, 8'h73};
    mem[8'hFE] = 8'h71; mem[8'hFF] = 8'h72; mem[8'h00] = 8'h73;
    clear_logs();
    done_delay = 1;
    start_seq(8'd0, 8'hFE, 8'd3);
    wait_not_busy("wrap");
    for (int i = 0; i < 3; i++) begin
      checks++;
      g = (i < rd_addr_q.size()) ? rd_addr_q[i] : 8'hxx;
      if (g !== ea[i]) begin failures++; $display("FAIL wr_rd_addr[%0d] got=%h exp=%h", i, g, ea[i]); end
      checks++;
      g = (i < out_q.size()) ? out_q[i] : 8'hxx;
      if (g !== eo[i]) begin failures++; $display("FAIL wr_out_data[%0d] got=%h exp=%h", i, g, eo[i]); end
    end
  endtask

  task automatic test_reset_mid;
    int n;
    logic [7:0] g;
    clear_logs();
    done_delay = 1;
    src_q = '{8'h91, 8'h92, 8'h93, 8'h94, 8'h95};
    start_seq(8'd5, 8'h00, 8'd0);
    n = 0;
    while (wr_addr_q.size() < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (wr_addr_q.size() != 2 || mem_wr_en !== 1'b1) begin
      failures++; $display("FAIL rm_precond writes=%0d wr_en=%b exp=2/1", wr_addr_q.size(), mem_wr_en);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({busy, in_ready, mem_wr_en, core_req, out_valid, timeout_err} !== 6'b0 || mem_addr !== 8'h00 || out_data !== 8'h00 || run_cycles !== 16'd0) begin
      failures++; $display("FAIL rm_outputs flags=%b mem_addr=%h out_data=%h run_cycles=%0d exp=all 0", {busy, in_ready, mem_wr_en, core_req, out_valid, timeout_err}, mem_addr, out_data, run_cycles);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_addr_q.size() != 2) begin failures++; $display("FAIL rm_no_more_writes got=%0d exp=2", wr_addr_q.size()); end
    src_q.delete();
    reset = 1'b1;
    @(negedge clk);
    clear_logs();
    src_q = '{8'hE1, 8'hE2};
    start_seq(8'd2, 8'h00, 8'd0);
    wait_not_busy("reset_mid");
    for (int i = 0; i < 2; i++) begin
      checks++;
      g = (i < wr_addr_q.size()) ? wr_addr_q[i] : 8'hxx;
      if (g !== 8'(i)) begin failures++; $display("FAIL rm_reload_addr[%0d] got=%h exp=%h", i, g, 8'(i)); end
    end
    checks++;
    g = (wr_data_q.size() > 0) ? wr_data_q[0] : 8'hxx;
    if (g !== 8'hE1) begin failures++; $display("FAIL rm_reload_data got=%h exp=e1", g); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    clear_logs();
    test_reset();
    test_load_unload();
    test_backpressure_gaps();
    test_timeout();
    test_zero_early_done();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
